// File: rtl/led_pkg.sv
// Shared types and helpers for the LED counter family and other blink/heartbeat blocks.
package led_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  // Step divider; a zero step rate yields 0 so the caller's range check trips.
  function automatic int unsigned div_of(input int unsigned clk_freq, input int unsigned step_hz);
    return (step_hz == 0) ? 0 : clk_freq / step_hz;
  endfunction

endpackage

// File: rtl/led_counter_ext_tick_gen.sv
// Prescaler: one-cycle tick every DIV enabled cycles; cleared while disabled or on clr.
module tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pc;

  assign tick = en && (pc == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (!en || clr || tick) begin
      pc <= '0;
    end else begin
      pc <= pc + PW'(1);
    end
  end

endmodule

// File: rtl/led_counter_ext.sv
// LED bank counter with modulus, direction, wrap/bounce modes, load and boundary strobe.
//   state    | meaning
//   DIR_UP   | bounce mode counts upward toward MAX_COUNT
//   DIR_DOWN | bounce mode counts downward toward 0
module led_counter_ext
  import led_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 7,
  parameter int unsigned CLK_FREQ  = 25_000_000,
  parameter int unsigned STEP_HZ   = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] leds,
  output logic             boundary
);

  localparam int unsigned DIV = div_of(CLK_FREQ, STEP_HZ);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MAX_COUNT - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  if (DIV < 1) begin : g_bad_div
    $error("led_counter_ext: CLK_FREQ/STEP_HZ must be at least 1");
  end
  if (MAX_COUNT < 1) begin : g_bad_max_lo
    $error("led_counter_ext: MAX_COUNT must be at least 1");
  end
  if ((64'(MAX_COUNT) >> WIDTH) != 64'd0) begin : g_bad_max_hi
    $error("led_counter_ext: MAX_COUNT does not fit in WIDTH bits");
  end

  logic             tick;
  logic [WIDTH-1:0] load_clamped;
  logic             at_top;
  logic             at_bot;
  dir_e             dir_q;
  dir_e             dir_d;
  logic [WIDTH-1:0] leds_d;
  logic             boundary_d;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
  assign at_top       = (leds == MAX_V) || (leds == MAX_M1);
  assign at_bot       = (leds == '0) || (leds == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DIR_UP;
    end else begin
      dir_q <= dir_d;
    end
  end

  // In wrap mode the FSM shadows the dir pin so a switch to bounce keeps going the same way.
  always_comb begin
    dir_d = dir_q;
    if (mode == MODE_WRAP) begin
      dir_d = dir ? DIR_UP : DIR_DOWN;
    end else if (load) begin
      if (load_clamped == '0) begin
        dir_d = DIR_UP;
      end else if (load_clamped == MAX_V) begin
        dir_d = DIR_DOWN;
      end
    end else if (tick) begin
      case (dir_q)
        DIR_UP:   if (at_top) dir_d = DIR_DOWN;
        DIR_DOWN: if (at_bot) dir_d = DIR_UP;
        default:  dir_d = DIR_UP;
      endcase
    end
  end

  always_comb begin
    leds_d     = leds;
    boundary_d = 1'b0;
    if (load) begin
      leds_d = load_clamped;
    end else if (tick) begin
      if (mode == MODE_BOUNCE) begin
        if (dir_q == DIR_UP) begin
          if (at_top) begin
            leds_d     = MAX_V;
            boundary_d = 1'b1;
          end else begin
            leds_d = leds + ONE;
          end
        end else begin
          if (at_bot) begin
            leds_d     = '0;
            boundary_d = 1'b1;
          end else begin
            leds_d = leds - ONE;
          end
        end
      end else if (dir) begin
        if (leds == MAX_V) begin
          leds_d     = '0;
          boundary_d = 1'b1;
        end else begin
          leds_d = leds + ONE;
        end
      end else begin
        if (leds == '0) begin
          leds_d     = MAX_V;
          boundary_d = 1'b1;
        end else begin
          leds_d = leds - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds     <= '0;
      boundary <= 1'b0;
    end else begin
      leds     <= leds_d;
      boundary <= boundary_d;
    end
  end

endmodule

// File: tb/tb_led_counter_ext.sv
// Bench for led_counter_ext: several parameterisations driven in parallel against a reference model.
module tb_led_counter_ext;

  localparam int NI = 5;
  localparam int unsigned CLK_HZ = 25_000_000;
  localparam int unsigned MAXS [NI] = '{7, 7, 5, 3, 1};
  localparam int unsigned DIVS [NI] = '{1, 4, 1, 1, 1};

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] leds_o [NI];
  logic       bnd_o  [NI];

  int n_chk;
  int n_pass;

  int unsigned m_leds [NI];
  int unsigned m_pc   [NI];
  bit          m_up   [NI];
  bit          m_bnd  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    led_counter_ext #(
      .WIDTH    (8),
      .MAX_COUNT(MAXS[g]),
      .CLK_FREQ (CLK_HZ),
      .STEP_HZ  (CLK_HZ / DIVS[g])
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .dir     (dir),
      .mode    (mode),
      .load    (load),
      .load_val(load_val),
      .leds    (leds_o[g]),
      .boundary(bnd_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_leds[i] = 0;
      m_pc[i]   = 0;
      m_up[i]   = 1'b1;
      m_bnd[i]  = 1'b0;
    end
  endtask

  // Counting is arithmetic on the range 0..max: wrap is modulo (max+1), bounce clamps at the ends.
  task automatic model_edge();
    int unsigned mx;
    int unsigned lv;
    bit tk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      mx = MAXS[i];
      tk = en && (m_pc[i] == DIVS[i] - 1);
      m_bnd[i] = 1'b0;
      if (load) begin
        lv = (int'(load_val) > mx) ? mx : int'(load_val);
        m_leds[i] = lv;
        m_pc[i]   = 0;
        if (mode) begin
          if (lv == 0) m_up[i] = 1'b1;
          else if (lv == mx) m_up[i] = 1'b0;
        end
      end else begin
        if (tk) begin
          if (!mode) begin
            m_leds[i] = dir ? (m_leds[i] + 1) % (mx + 1) : (m_leds[i] + mx) % (mx + 1);
            m_bnd[i]  = dir ? (m_leds[i] == 0) : (m_leds[i] == mx);
          end else if (m_up[i]) begin
            if (m_leds[i] + 1 >= mx) begin
              m_leds[i] = mx; m_up[i] = 1'b0; m_bnd[i] = 1'b1;
            end else m_leds[i] = m_leds[i] + 1;
          end else begin
            if (m_leds[i] <= 1) begin
              m_leds[i] = 0; m_up[i] = 1'b1; m_bnd[i] = 1'b1;
            end else m_leds[i] = m_leds[i] - 1;
          end
        end
        m_pc[i] = (!en || tk) ? 0 : m_pc[i] + 1;
      end
      if (!mode) m_up[i] = dir;
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input logic e, input logic d, input logic m);
    rst_n = 1'b0;
    load  = 1'b0;
    en    = e;
    dir   = d;
    mode  = m;
    model_reset();
    repeat (2) step_clk();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NI; i++) begin
      n_chk++;
      if (leds_o[i] !== 8'd0 || bnd_o[i] !== 1'b0)
        $display("FAIL reset inst%0d: leds=%0d boundary=%b, required leds=0 boundary=0", i, leds_o[i], bnd_o[i]);
      else n_pass++;
    end
  endtask

  task automatic test_legacy();
    int unsigned exp_l [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    do_reset(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      step_clk();
      n_chk++;
      if (leds_o[0] !== 8'(exp_l[k]) || bnd_o[0] !== (exp_l[k] == 0))
        $display("FAIL legacy cycle%0d: leds=%0d boundary=%b, required leds=%0d boundary=%b",
                 k + 1, leds_o[0], bnd_o[0], exp_l[k], exp_l[k] == 0);
      else n_pass++;
    end
  endtask

  task automatic test_prescaler();
    do_reset(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step_clk();
      n_chk++;
      if (leds_o[1] !== 8'(k / 4) || bnd_o[1] !== 1'b0)
        $display("FAIL prescaler cycle%0d: leds=%0d boundary=%b, required leds=%0d boundary=0", k, leds_o[1], bnd_o[1], k / 4);
      else n_pass++;
    end
    en = 1'b0;
    repeat (3) step_clk();
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step_clk();
      n_chk++;
      if (leds_o[1] !== ((k == 4) ? 8'd3 : 8'd2))
        $display("FAIL prescaler_reenable cycle%0d: leds=%0d, required %0d", k, leds_o[1], (k == 4) ? 3 : 2);
      else n_pass++;
    end
  endtask

  task automatic test_down_wrap();
    int unsigned exp_l [7] = '{5, 4, 3, 2, 1, 0, 5};
    do_reset(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step_clk();
      n_chk++;
      if (leds_o[2] !== 8'(exp_l[k]) || bnd_o[2] !== (exp_l[k] == 5))
        $display("FAIL down_wrap step%0d: leds=%0d boundary=%b, required leds=%0d boundary=%b",
                 k + 1, leds_o[2], bnd_o[2], exp_l[k], exp_l[k] == 5);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int unsigned exp3 [7] = '{1, 2, 3, 2, 1, 0, 1};
    int unsigned exp1 [3] = '{1, 0, 1};
    do_reset(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step_clk();
      n_chk++;
      if (leds_o[3] !== 8'(exp3[k]) || bnd_o[3] !== (k == 2 || k == 5))
        $display("FAIL bounce_max3 step%0d: leds=%0d boundary=%b, required leds=%0d boundary=%b",
                 k + 1, leds_o[3], bnd_o[3], exp3[k], k == 2 || k == 5);
      else n_pass++;
      if (k < 3) begin
        n_chk++;
        if (leds_o[4] !== 8'(exp1[k]) || bnd_o[4] !== 1'b1)
          $display("FAIL bounce_max1 step%0d: leds=%0d boundary=%b, required leds=%0d boundary=1",
                   k + 1, leds_o[4], bnd_o[4], exp1[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_load();
    do_reset(1'b1, 1'b1, 1'b0);
    load = 1'b1; load_val = 8'd200;
    step_clk();
    n_chk++;
    if (leds_o[0] !== 8'd7 || bnd_o[0] !== 1'b0)
      $display("FAIL load_clamp: leds=%0d boundary=%b, required leds=7 boundary=0", leds_o[0], bnd_o[0]);
    else n_pass++;
    load = 1'b0;
    repeat (3) step_clk();
    load = 1'b1; load_val = 8'd7;
    step_clk();
    n_chk++;
    if (leds_o[1] !== 8'd7 || bnd_o[1] !== 1'b0)
      $display("FAIL load_vs_tick: leds=%0d boundary=%b, required leds=7 boundary=0", leds_o[1], bnd_o[1]);
    else n_pass++;
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step_clk();
      n_chk++;
      if (leds_o[1] !== ((k == 4) ? 8'd0 : 8'd7) || bnd_o[1] !== (k == 4))
        $display("FAIL load_pc_restart cycle%0d: leds=%0d boundary=%b, required leds=%0d boundary=%b",
                 k, leds_o[1], bnd_o[1], (k == 4) ? 0 : 7, k == 4);
      else n_pass++;
    end
    mode = 1'b1; load = 1'b1; load_val = 8'd3;
    step_clk();
    load = 1'b0;
    step_clk();
    n_chk++;
    if (leds_o[3] !== 8'd2)
      $display("FAIL load_bounce_top: leds=%0d, required 2", leds_o[3]);
    else n_pass++;
    load = 1'b1; load_val = 8'd0;
    step_clk();
    load = 1'b0;
    step_clk();
    n_chk++;
    if (leds_o[3] !== 8'd1 || bnd_o[3] !== 1'b0)
      $display("FAIL load_bounce_zero: leds=%0d boundary=%b, required leds=1 boundary=0", leds_o[3], bnd_o[3]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset(1'b0, 1'b1, 1'b1);
    load = 1'b1; load_val = 8'd5;
    step_clk();
    load = 1'b0;
    step_clk();
    n_chk++;
    if (leds_o[2] !== 8'd5)
      $display("FAIL async_setup: leds=%0d, required 5", leds_o[2]);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      n_chk++;
      if (leds_o[i] !== 8'd0 || bnd_o[i] !== 1'b0)
        $display("FAIL async_reset inst%0d: leds=%0d boundary=%b, required leds=0 boundary=0", i, leds_o[i], bnd_o[i]);
      else n_pass++;
    end
    step_clk();
    rst_n = 1'b1;
    en = 1'b1;
    step_clk();
    n_chk++;
    if (leds_o[2] !== 8'd1 || bnd_o[2] !== 1'b0)
      $display("FAIL async_release_up: leds=%0d boundary=%b, required leds=1 boundary=0", leds_o[2], bnd_o[2]);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 1500; k++) begin
      en       = ($urandom_range(0, 9) != 0);
      dir      = ($urandom_range(0, 15) != 0) ? dir : ~dir;
      mode     = ($urandom_range(0, 31) != 0) ? mode : ~mode;
      load     = ($urandom_range(0, 24) == 0);
      load_val = 8'($urandom);
      step_clk();
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if (leds_o[i] !== 8'(m_leds[i]) || bnd_o[i] !== m_bnd[i])
          $display("FAIL random cycle%0d inst%0d: leds=%0d boundary=%b, required leds=%0d boundary=%b",
                   k, i, leds_o[i], bnd_o[i], m_leds[i], m_bnd[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    dir      = 1'b1;
    mode     = 1'b0;
    load     = 1'b0;
    load_val = 8'd0;
    model_reset();
    test_reset();
    test_legacy();
    test_prescaler();
    test_down_wrap();
    test_bounce();
    test_load();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_counter_ext.md
# led_counter_ext

Parametrised LED counter for board bring-up and status display. Divides the system clock into a step tick and drives a WIDTH-bit count onto the LED bank. Adds the following to the fixed 0..7 up-counter: configurable modulus, up/down direction, a wrap or ping-pong (bounce) mode, enable, synchronous load, and a boundary pulse. Sits between the board clock/reset and the LED pins; a parent may also use `boundary` as a slow event strobe.

## Interface
- `WIDTH`, default 8: counter and LED width in bits, 1..32.
- `MAX_COUNT`, default 7: highest count value, 1..2^WIDTH-1; the count range is 0..MAX_COUNT.
- `CLK_FREQ`, default 25_000_000: clock frequency in Hz.
- `STEP_HZ`, default 25_000_000: step rate in Hz; DIV = CLK_FREQ/STEP_HZ, integer, ≥1. DIV=1 steps every enabled cycle.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: step enable; low freezes the count and clears the prescaler.
- `dir` in 1: wrap-mode direction, 1=up, 0=down.
- `mode` in 1: 0=wrap, 1=bounce.
- `load` in 1: synchronous load strobe.
- `load_val` in WIDTH: load value.
- `leds` out WIDTH: current count, registered.
- `boundary` out 1: one-cycle pulse on a wrap or a bounce reversal, registered.

## Operation
- **Prescaler `pc`** (width clog2(DIV), min 1):
  - Counts 0..DIV-1 while `en`=1.
  - `tick` = `en` & (`pc`==DIV-1).
  - `pc` clears to 0 on `tick`, when `en`=0, and on `load`.
- **Priority per cycle:** `load` > `tick` step > hold.
- **Load:** `leds` <= min(`load_val`, MAX_COUNT); `boundary` <= 0; `pc` <= 0. In bounce mode, `dir_q` <= UP if the loaded value is 0, DOWN if it is MAX_COUNT, otherwise unchanged.
- **Wrap mode, `tick`:**
  - `dir`=1: MAX_COUNT→0 with `boundary`=1; otherwise +1.
  - `dir`=0: 0→MAX_COUNT with `boundary`=1; otherwise −1.
- **Bounce mode, `tick`:** two-state FSM `dir_q` ∈ {UP, DOWN}; the `dir` input is ignored.
  - UP: if `leds`==MAX_COUNT−1 or `leds`==MAX_COUNT, go to MAX_COUNT, set `dir_q`=DOWN, `boundary`=1; else +1.
  - DOWN: if `leds`==1 or `leds`==0, go to 0, set `dir_q`=UP, `boundary`=1; else −1.
  - Sequence for MAX_COUNT=3: 0,1,2,3,2,1,0,1…
  - `boundary` pulses on the step that reaches each endpoint.
  - MAX_COUNT=1: alternates 0,1,0,1 with `boundary` on every step.
- **`dir_q` tracking:** while `mode`=0, `dir_q` follows `dir` every cycle (1→UP, 0→DOWN). Switching to bounce therefore continues in the last wrap direction.
- **Mode change:** a mode change takes effect on the next tick; `leds` is never altered by the mode change itself.
- **Arithmetic:** WIDTH-bit modular, compared against MAX_COUNT only; `leds` never exceeds MAX_COUNT.
- **`boundary` default:** 0 on every cycle without a qualifying step.

## Timing
- **Reset (async assert, sync release by the parent):** `leds`=0, `boundary`=0, `pc`=0, `dir_q`=UP.
- **Step latency:** `leds` changes on the clock edge where `tick`=1, visible the following cycle. `boundary` is registered on the same edge as its `leds` update.
- **Enable latency:** the first step after `en` rises occurs DIV cycles later.
- **DIV=1, MAX_COUNT=7, `en`=1, `dir`=1, `mode`=0:** `leds` goes 1,2,…,7,0,1… on consecutive cycles after reset release.
- **Simultaneous `load` & `tick`:** the load wins, the step is lost, and `pc` restarts.
- **Reset mid-count:** immediate return to reset values; no `boundary` glitch.

## Structure
- **Shared package `led_pkg`:**
  - direction enum {DIR_DOWN=0, DIR_UP=1}
  - mode constants MODE_WRAP=0, MODE_BOUNCE=1
  - function `div_of(CLK_FREQ, STEP_HZ)`
- **Sub-module `tick_gen`:** holds the prescaler; parameter DIV; ports `clk`, `rst_n`, `en`, `clr`, `tick`. It is reusable by other blink/heartbeat blocks.
- **Top level:** count register, `dir_q` FSM and `boundary` register.
- **Elaboration-time assertions:** DIV ≥ 1, MAX_COUNT < 2^WIDTH, MAX_COUNT ≥ 1.

## Test plan
- **Legacy equivalence:** DIV=1, WIDTH=8, MAX_COUNT=7, `en`=1, `dir`=1, `mode`=0. After reset, `leds` = 1..7,0,1 on cycles 1..9; `boundary`=1 only in the cycle `leds`=0 appears.
- **Prescaler/enable:** DIV=4. Expect a step every 4 cycles. Drop `en` for 3 cycles mid-period: `leds` holds, and the next step comes 4 cycles after `en` returns.
- **Down-wrap:** DIV=1, MAX_COUNT=5, `dir`=0 from 0. Expect `leds`=5,4,3,2,1,0,5 with `boundary` on the steps to 5.
- **Bounce:** MAX_COUNT=3, `mode`=1 from reset. Expect `leds`=1,2,3,2,1,0,1; `boundary` at 3 and at 0. Then MAX_COUNT=1: 1,0,1 with `boundary` each step.
- **Load:** `load_val`=200 with MAX_COUNT=7 gives `leds`=7. Assert `load`=1 coincident with `tick`: the step is suppressed. In bounce, loading 0 sets UP and the next step gives 1.
- **Async reset:** assert `rst_n` low mid-period with `leds`=5, bounce DOWN. Outputs go to 0 immediately, without waiting for a clock edge. After release, the first step gives 1 (UP).
